// File: rtl/sdram_read_arbiter.sv
// Round-robin read arbiter in front of a single-port SDRAM read model.
// Only one read is in flight at a time: IDLE -> ISSUE -> WAIT -> RESP.
module sdram_read_arbiter #(
    parameter int NREQ    = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_i,
    input  logic [NREQ*ADDR_W-1:0]   req_addr_i,
    output logic [NREQ-1:0]          ack_o,
    output logic                     err_o,
    output logic [DATA_W-1:0]        rdata_o,
    output logic                     busy_o,
    output logic                     mem_read_o,
    output logic [ADDR_W-1:0]        mem_addr_o,
    input  logic [DATA_W-1:0]        mem_data_i,
    input  logic                     data_valid_i
);

    localparam int IDX_W = $clog2(NREQ);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [IDX_W:0]   NREQ_C = NREQ[IDX_W:0];
    localparam logic [CNT_W-1:0] TO_C   = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]     gnt_q, gnt_d;
    logic [CNT_W-1:0]     wait_cnt_q, wait_cnt_d;
    logic [NREQ-1:0]      ack_q, ack_d;
    logic                 err_q, err_d;
    logic [DATA_W-1:0]    rdata_q, rdata_d;
    logic                 mem_read_q, mem_read_d;
    logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;

    logic                 found;
    logic [IDX_W-1:0]     pick;
    logic [IDX_W:0]       idx;
    logic [ADDR_W-1:0]    sel_addr;

    // Scan rr_ptr, rr_ptr+1, ... wrapping at NREQ; first requester found wins.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = {1'b0, rr_ptr_q} + k[IDX_W:0];
            if (idx >= NREQ_C) idx = idx - NREQ_C;
            if (!found && req_i[idx[IDX_W-1:0]]) begin
                found = 1'b1;
                pick  = idx[IDX_W-1:0];
            end
        end
        sel_addr = req_addr_i[pick*ADDR_W +: ADDR_W];
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        gnt_d      = gnt_q;
        wait_cnt_d = wait_cnt_q;
        ack_d      = '0;
        err_d      = err_q;
        rdata_d    = rdata_q;
        mem_read_d = 1'b0;
        mem_addr_d = mem_addr_q;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    gnt_d      = pick;
                    mem_addr_d = {sel_addr[ADDR_W-1:2], 2'b00};
                    mem_read_d = 1'b1;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                wait_cnt_d = '0;
                state_d    = WAIT;
            end
            WAIT: begin
                // Timeout fires on the TIMEOUT-th WAIT cycle without data_valid.
                if (data_valid_i) begin
                    rdata_d = mem_data_i;
                    err_d   = 1'b0;
                    ack_d   = NREQ'(1) << gnt_q;
                    state_d = RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                    if (wait_cnt_q + 1'b1 == TO_C) begin
                        err_d   = 1'b1;
                        ack_d   = NREQ'(1) << gnt_q;
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                rr_ptr_d = (gnt_q == IDX_W'(NREQ - 1)) ? '0 : gnt_q + 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            gnt_q      <= '0;
            wait_cnt_q <= '0;
            ack_q      <= '0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
            mem_read_q <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            gnt_q      <= gnt_d;
            wait_cnt_q <= wait_cnt_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
            mem_read_q <= mem_read_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    assign ack_o      = ack_q;
    assign err_o      = err_q;
    assign rdata_o    = rdata_q;
    assign busy_o     = (state_q != IDLE);
    assign mem_read_o = mem_read_q;
    assign mem_addr_o = mem_addr_q;

endmodule

// File: tb/tb_sdram_read_arbiter.sv
// Directed bench for sdram_read_arbiter: vector table plus hand-written
// sequences for continuous demand, early req drop and mid-transaction reset.
module tb_sdram_read_arbiter;

    localparam int NREQ = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        req;
    logic [31:0]       a0, a1;
    logic [1:0]        ack;
    logic              err;
    logic [31:0]       rdata;
    logic              busy;
    logic              mem_read;
    logic [31:0]       mem_addr;
    logic [31:0]       mem_data = '0;
    logic              data_valid = 1'b0;
    logic              dv_en;
    logic              prev_mr = 1'b0;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    sdram_read_arbiter #(.NREQ(NREQ), .ADDR_W(32), .DATA_W(32), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .req_i(req), .req_addr_i({a1, a0}),
        .ack_o(ack), .err_o(err), .rdata_o(rdata), .busy_o(busy),
        .mem_read_o(mem_read), .mem_addr_o(mem_addr),
        .mem_data_i(mem_data), .data_valid_i(data_valid)
    );

    // SDRAM model: mem[i] = i+1, one-cycle registered read latency.
    always @(posedge clk) begin
        data_valid <= mem_read & dv_en;
        if (mem_read) mem_data <= (mem_addr >> 2) + 32'd1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("mem_read_consecutive", {63'd0, prev_mr & mem_read}, 64'd0);
            chk("ack_onehot", {63'd0, $onehot0(ack)}, 64'd1);
        end
        prev_mr <= mem_read;
    end

    typedef struct {
        logic [1:0]  req;
        logic [31:0] a0;
        logic [31:0] a1;
        logic        dv;
        logic [1:0]  ack;
        logic [31:0] addr;
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } vec_t;

    // Starts at an IDLE negedge, ends at the following IDLE negedge.
    task automatic run_vec(input vec_t v, input int n);
        int lat = 0, pulses = 0;
        logic [31:0] seen = '0;
        req = v.req; a0 = v.a0; a1 = v.a1; dv_en = v.dv;
        for (int c = 1; c <= 40 && lat == 0; c++) begin
            @(negedge clk);
            if (mem_read) begin pulses++; seen = mem_addr; end
            if (ack != 2'b00) lat = c;
        end
        req = 2'b00;
        chk($sformatf("v%0d_latency", n), 64'(lat), 64'(v.lat));
        chk($sformatf("v%0d_ack", n), 64'(ack), 64'(v.ack));
        chk($sformatf("v%0d_rdata", n), 64'(rdata), 64'(v.rdata));
        chk($sformatf("v%0d_err", n), 64'(err), 64'(v.err));
        chk($sformatf("v%0d_mem_addr", n), 64'(seen), 64'(v.addr));
        chk($sformatf("v%0d_read_pulses", n), 64'(pulses), 64'd1);
        @(negedge clk);
        chk($sformatf("v%0d_idle_after", n), 64'({busy, ack}), 64'd0);
        dv_en = 1'b1;
    endtask

    initial begin
        vec_t vecs[8];
        int   n_ack;
        logic [1:0]  acks[4];
        logic [31:0] rds[4];
        int   cycs[4];
        int   lat;

        //        req    a0            a1            dv    ack    addr          rdata         err  lat
        vecs[0] = '{2'b01, 32'h10,       32'h0,        1'b1, 2'b01, 32'h10,       32'h5,        1'b0, 3};
        vecs[1] = '{2'b10, 32'h0,        32'h13,       1'b1, 2'b10, 32'h10,       32'h5,        1'b0, 3};
        vecs[2] = '{2'b11, 32'h0,        32'h4,        1'b1, 2'b01, 32'h0,        32'h1,        1'b0, 3};
        vecs[3] = '{2'b11, 32'h0,        32'h4,        1'b1, 2'b10, 32'h4,        32'h2,        1'b0, 3};
        vecs[4] = '{2'b10, 32'h0,        32'h100,      1'b1, 2'b10, 32'h100,      32'h41,       1'b0, 3};
        vecs[5] = '{2'b01, 32'h20,       32'h0,        1'b0, 2'b01, 32'h20,       32'h41,       1'b1, 17};
        vecs[6] = '{2'b01, 32'h20,       32'h0,        1'b1, 2'b01, 32'h20,       32'h9,        1'b0, 3};
        vecs[7] = '{2'b11, 32'h8,        32'hFFFF_FFF0, 1'b1, 2'b10, 32'hFFFF_FFF0, 32'h3FFF_FFFD, 1'b0, 3};

        rst = 1'b1; req = '0; a0 = '0; a1 = '0; dv_en = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {ack, err, busy, mem_read}, 64'd0);
        chk("reset_data", {rdata, mem_addr}, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_idle", {ack, busy, mem_read}, 64'd0);

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // Continuous demand: grants alternate every 4 cycles.
        n_ack = 0;
        req = 2'b11; a0 = 32'h0; a1 = 32'h4;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (ack != 2'b00 && n_ack < 4) begin
                acks[n_ack] = ack; rds[n_ack] = rdata; cycs[n_ack] = c; n_ack++;
            end
        end
        req = 2'b00;
        chk("cont_count", 64'(n_ack), 64'd3);
        if (n_ack >= 3) begin
            chk("cont_ack0", 64'(acks[0]), 64'b01);
            chk("cont_ack1", 64'(acks[1]), 64'b10);
            chk("cont_ack2", 64'(acks[2]), 64'b01);
            chk("cont_rdata0", 64'(rds[0]), 64'd1);
            chk("cont_rdata1", 64'(rds[1]), 64'd2);
            chk("cont_rdata2", 64'(rds[2]), 64'd1);
            chk("cont_cyc0", 64'(cycs[0]), 64'd3);
            chk("cont_cyc1", 64'(cycs[1]), 64'd7);
            chk("cont_cyc2", 64'(cycs[2]), 64'd11);
        end
        repeat (2) @(negedge clk);

        // req dropped during ISSUE: transaction still completes.
        req = 2'b10; a1 = 32'h30;
        @(negedge clk);
        req = 2'b00;
        lat = 0;
        for (int c = 2; c <= 20 && lat == 0; c++) begin
            @(negedge clk);
            if (ack != 2'b00) lat = c;
        end
        chk("drop_latency", 64'(lat), 64'd3);
        chk("drop_ack", 64'(ack), 64'b10);
        chk("drop_rdata", 64'(rdata), 64'hD);
        @(negedge clk);

        // Reset during WAIT aborts the read with no ack.
        req = 2'b01; a0 = 32'h10;
        @(negedge clk);
        @(negedge clk);
        chk("rst_mid_in_wait", 64'(busy), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_outputs", {ack, err, busy, mem_read}, 64'd0);
        chk("rst_mid_data", {rdata, mem_addr}, 64'd0);
        rst = 1'b0; req = 2'b00;
        @(negedge clk);
        chk("rst_mid_no_ack", 64'(ack), 64'd0);
        // rr_ptr back at 0: requester 0 wins a tie.
        run_vec('{2'b11, 32'h0, 32'h4, 1'b1, 2'b01, 32'h0, 32'h1, 1'b0, 3}, 8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
